// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM pipeline stage and the data memory controller.
// The pipeline side drives a request while Ready is high; the controller answers
// with a one-cycle Done pulse carrying the read data and the error status.
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              Enable;
  logic              ReadWrite;
  logic              SE;
  logic [1:0]        Size;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       DataIn;
  logic [31:0]       DataOut;
  logic              Ready;
  logic              Done;
  logic              Err;

  modport master (
    output Enable, ReadWrite, SE, Size, Address, DataIn,
    input  DataOut, Ready, Done, Err
  );

  modport slave (
    input  Enable, ReadWrite, SE, Size, Address, DataIn,
    output DataOut, Ready, Done, Err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Clocked big-endian byte-addressed data memory with a request/ready/done handshake.
// A request is latched when Ready and Enable are both high, held for WAIT_STATES
// extra cycles, then completed in one edge: the access is checked for size, range
// and alignment, bytes are written or read, and Done pulses with Err.
module data_memory_ctrl #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              Clk,
  input  logic              ResetN,
  data_memory_ctrl_if.slave bus
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              EW      = ADDR_W + 2;
  localparam logic [EW-1:0]   DEPTH_X = EW'(DEPTH);
  localparam logic [3:0]      WS_INIT = 4'(WAIT_STATES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic              rw_q, rw_d;
  logic              se_q, se_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       dout_q, dout_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;

  logic [7:0]        mem [DEPTH];

  logic [EW-1:0]       n_bytes;
  logic [EW-1:0]       last_addr;
  logic                range_err;
  logic                misalign;
  logic                access_err;
  logic [3:0][EW-1:0]  byte_addr;
  logic [3:0][7:0]     rd_byte;
  logic [31:0]         rd_word;
  logic [3:0][7:0]     wr_byte;
  logic [3:0]          lane_en;
  logic                wr_en;

  // Decode the latched access: width, legality, read assembly and write lanes.
  always_comb begin
    case (size_q)
      2'b00:   n_bytes = EW'(1);
      2'b01:   n_bytes = EW'(2);
      2'b10:   n_bytes = EW'(4);
      default: n_bytes = EW'(1);
    endcase

    last_addr  = {2'b00, addr_q} + n_bytes - EW'(1);
    range_err  = (last_addr >= DEPTH_X);
    misalign   = (ALIGN_CHECK != 0) &&
                 (((size_q == 2'b01) && addr_q[0]) ||
                  ((size_q == 2'b10) && (addr_q[1:0] != 2'b00)));
    access_err = (size_q == 2'b11) || range_err || misalign;

    for (int k = 0; k < 4; k++) begin
      byte_addr[k] = {2'b00, addr_q} + EW'(k);
      rd_byte[k]   = (byte_addr[k] < DEPTH_X) ? mem[byte_addr[k][IDX_W-1:0]] : 8'h00;
    end

    case (size_q)
      2'b00:   rd_word = {{24{se_q & rd_byte[0][7]}}, rd_byte[0]};
      2'b01:   rd_word = {{16{se_q & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
      default: rd_word = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
    endcase

    wr_byte = '0;
    lane_en = 4'b0000;
    case (size_q)
      2'b00: begin
        lane_en    = 4'b0001;
        wr_byte[0] = wdata_q[7:0];
      end
      2'b01: begin
        lane_en    = 4'b0011;
        wr_byte[0] = wdata_q[15:8];
        wr_byte[1] = wdata_q[7:0];
      end
      2'b10: begin
        lane_en    = 4'b1111;
        wr_byte[0] = wdata_q[31:24];
        wr_byte[1] = wdata_q[23:16];
        wr_byte[2] = wdata_q[15:8];
        wr_byte[3] = wdata_q[7:0];
      end
      default: begin
        lane_en = 4'b0000;
      end
    endcase
  end

  // Next-state logic: accept in IDLE, count wait states in BUSY, then complete.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rw_d    = rw_q;
    se_d    = se_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ready_d = ready_q;
    wr_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ready_q && bus.Enable) begin
          rw_d    = bus.ReadWrite;
          se_d    = bus.SE;
          size_d  = bus.Size;
          addr_d  = bus.Address;
          wdata_d = bus.DataIn;
          count_d = WS_INIT;
          state_d = BUSY;
          ready_d = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      BUSY: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          done_d  = 1'b1;
          err_d   = access_err;
          ready_d = 1'b1;
          state_d = IDLE;
          if (!access_err) begin
            if (rw_q) begin
              wr_en = 1'b1;
            end else begin
              dout_d = rd_word;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and latched-request registers; reset aborts any transaction in flight.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      rw_q    <= 1'b0;
      se_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      dout_q  <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rw_q    <= rw_d;
      se_q    <= se_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  // Byte array write port; contents are deliberately left unreset.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) begin
          mem[byte_addr[k][IDX_W-1:0]] <= wr_byte[k];
        end
      end
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.Ready   = ready_q;
  assign bus.Done    = done_q;
  assign bus.Err     = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: one instance with one wait state, one with none.
// Requests push their expected Err/DataOut to a per-instance queue; a monitor pops
// and compares on every Done pulse, so results must arrive in request order.
module tb_data_memory_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] dout;
    logic        err;
  } exp_t;

  typedef struct {
    string       tag;
    logic [1:0]  size;
    logic        se;
    logic [8:0]  addr;
    logic [31:0] dout;
    logic        err;
  } req_t;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  exp_t sb1[$];
  exp_t sb0[$];

  data_memory_ctrl_if #(.ADDR_W(9)) bus1 ();
  data_memory_ctrl_if #(.ADDR_W(9)) bus0 ();

  data_memory_ctrl #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(1), .ALIGN_CHECK(1)) dut1 (
    .Clk(clk), .ResetN(rst_n), .bus(bus1.slave)
  );

  data_memory_ctrl #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(0), .ALIGN_CHECK(1)) dut0 (
    .Clk(clk), .ResetN(rst_n), .bus(bus0.slave)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic getReady(input int sel);
    return (sel == 1) ? bus1.Ready : bus0.Ready;
  endfunction

  function automatic logic getDone(input int sel);
    return (sel == 1) ? bus1.Done : bus0.Done;
  endfunction

  task automatic drive(input int sel, input logic en, input logic rw, input logic [1:0] size,
                       input logic se, input logic [8:0] addr, input logic [31:0] din);
    if (sel == 1) begin
      bus1.Enable = en; bus1.ReadWrite = rw; bus1.Size = size;
      bus1.SE = se; bus1.Address = addr; bus1.DataIn = din;
    end else begin
      bus0.Enable = en; bus0.ReadWrite = rw; bus0.Size = size;
      bus0.SE = se; bus0.Address = addr; bus0.DataIn = din;
    end
  endtask

  task automatic pushExpected(input int sel, input string tag, input logic [31:0] dout, input logic err);
    exp_t e;
    e.tag  = tag;
    e.dout = dout;
    e.err  = err;
    if (sel == 1) sb1.push_back(e);
    else          sb0.push_back(e);
  endtask

  task automatic waitReady(input int sel, input string tag);
    int guard = 0;
    while (getReady(sel) !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_ready"}, 32'(getReady(sel)), 32'd1);
  endtask

  // One isolated request with latency checks: Done exactly WAIT_STATES+1 edges after E0.
  task automatic applyStimulus(input int sel, input string tag, input logic rw, input logic [1:0] size,
                               input logic se, input logic [8:0] addr, input logic [31:0] din,
                               input logic [31:0] exp_dout, input logic exp_err);
    int ws;
    ws = (sel == 1) ? 1 : 0;
    waitReady(sel, tag);
    drive(sel, 1'b1, rw, size, se, addr, din);
    pushExpected(sel, tag, exp_dout, exp_err);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    checkOutput({tag, "_busy"}, 32'(getReady(sel)), 32'd0);
    checkOutput({tag, "_early0"}, 32'(getDone(sel)), 32'd0);
    for (int k = 0; k < ws; k++) begin
      @(negedge clk);
      checkOutput({tag, "_early"}, 32'(getDone(sel)), 32'd0);
    end
    @(negedge clk);
    checkOutput({tag, "_done"}, 32'(getDone(sel)), 32'd1);
  endtask

  // Scoreboard consumers: every Done pulse must match the oldest outstanding request.
  always @(negedge clk) begin : monitor
    exp_t e1;
    exp_t e0;
    if (bus1.Done === 1'b1) begin
      checkOutput("dut1_done_expected", 32'(sb1.size() != 0), 32'd1);
      if (sb1.size() != 0) begin
        e1 = sb1.pop_front();
        checkOutput({e1.tag, "_err"}, 32'(bus1.Err), 32'(e1.err));
        checkOutput({e1.tag, "_dout"}, bus1.DataOut, e1.dout);
        checkOutput({e1.tag, "_ready_with_done"}, 32'(bus1.Ready), 32'd1);
      end
    end
    if (bus0.Done === 1'b1) begin
      checkOutput("dut0_done_expected", 32'(sb0.size() != 0), 32'd1);
      if (sb0.size() != 0) begin
        e0 = sb0.pop_front();
        checkOutput({e0.tag, "_err"}, 32'(bus0.Err), 32'(e0.err));
        checkOutput({e0.tag, "_dout"}, bus0.DataOut, e0.dout);
      end
    end
  end

  // Directed sequence: reset, data paths, errors, reset abort, back-to-back.
  initial begin
    req_t b2b[4];
    int   guard;

    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);

    repeat (3) @(negedge clk);
    checkOutput("rst_dout1", bus1.DataOut, 32'h0);
    checkOutput("rst_done1", 32'(bus1.Done), 32'd0);
    checkOutput("rst_err1", 32'(bus1.Err), 32'd0);
    checkOutput("rst_ready1", 32'(bus1.Ready), 32'd0);
    checkOutput("rst_ready0", 32'(bus0.Ready), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ready1_low", 32'(bus1.Ready), 32'd0);
    @(negedge clk);
    checkOutput("rel_ready1_high", 32'(bus1.Ready), 32'd1);
    checkOutput("rel_ready0_high", 32'(bus0.Ready), 32'd1);

    applyStimulus(1, "w_word_010",  1'b1, 2'b10, 1'b0, 9'h010, 32'h8899AABB, 32'h00000000, 1'b0);
    applyStimulus(1, "r_word_010",  1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        32'h8899AABB, 1'b0);
    applyStimulus(1, "r_byte_se",   1'b0, 2'b00, 1'b1, 9'h010, 32'h0,        32'hFFFFFF88, 1'b0);
    applyStimulus(1, "r_half_se",   1'b0, 2'b01, 1'b1, 9'h012, 32'h0,        32'hFFFFAABB, 1'b0);
    applyStimulus(1, "r_half_ze",   1'b0, 2'b01, 1'b0, 9'h012, 32'h0,        32'h0000AABB, 1'b0);
    applyStimulus(1, "w_byte_013",  1'b1, 2'b00, 1'b0, 9'h013, 32'hFFFFFF7F, 32'h0000AABB, 1'b0);
    applyStimulus(1, "r_byte_7f",   1'b0, 2'b00, 1'b1, 9'h013, 32'h0,        32'h0000007F, 1'b0);
    applyStimulus(1, "r_word_mis",  1'b0, 2'b10, 1'b0, 9'h011, 32'h0,        32'h0000007F, 1'b1);
    applyStimulus(1, "w_half_1fe",  1'b1, 2'b01, 1'b0, 9'h1FE, 32'hDEAD5A5A, 32'h0000007F, 1'b0);
    applyStimulus(1, "w_word_oor",  1'b1, 2'b10, 1'b0, 9'h1FE, 32'h11223344, 32'h0000007F, 1'b1);
    applyStimulus(1, "r_half_1fe",  1'b0, 2'b01, 1'b0, 9'h1FE, 32'h0,        32'h00005A5A, 1'b0);
    applyStimulus(1, "size_rsvd",   1'b0, 2'b11, 1'b0, 9'h000, 32'h0,        32'h00005A5A, 1'b1);
    applyStimulus(1, "r_byte_1ff",  1'b0, 2'b00, 1'b1, 9'h1FF, 32'h0,        32'h0000005A, 1'b0);
    applyStimulus(1, "w_word_020",  1'b1, 2'b10, 1'b0, 9'h020, 32'hCAFEF00D, 32'h0000005A, 1'b0);

    waitReady(1, "abort");
    drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 9'h020, 32'h12345678);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);
    checkOutput("abort_busy", 32'(bus1.Ready), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_dout_rst", bus1.DataOut, 32'h0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(bus1.Done), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    checkOutput("abort_ready_low", 32'(bus1.Ready), 32'd0);
    @(negedge clk);
    checkOutput("abort_ready_high", 32'(bus1.Ready), 32'd1);
    checkOutput("abort_done_low", 32'(bus1.Done), 32'd0);
    applyStimulus(1, "r_word_020",  1'b0, 2'b10, 1'b0, 9'h020, 32'h0,        32'hCAFEF00D, 1'b0);

    applyStimulus(0, "ws0_w_040",   1'b1, 2'b10, 1'b0, 9'h040, 32'h01020304, 32'h00000000, 1'b0);
    applyStimulus(0, "ws0_w_044",   1'b1, 2'b10, 1'b0, 9'h044, 32'hA0B0C0D0, 32'h00000000, 1'b0);

    b2b[0] = '{"b2b_word",  2'b10, 1'b0, 9'h040, 32'h01020304, 1'b0};
    b2b[1] = '{"b2b_byte",  2'b00, 1'b1, 9'h044, 32'hFFFFFFA0, 1'b0};
    b2b[2] = '{"b2b_half",  2'b01, 1'b0, 9'h046, 32'h0000C0D0, 1'b0};
    b2b[3] = '{"b2b_mis",   2'b10, 1'b0, 9'h041, 32'h0000C0D0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b0, b2b[i].size, b2b[i].se, b2b[i].addr, 32'h0);
      guard = 0;
      while (bus0.Ready !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      checkOutput({b2b[i].tag, "_ready"}, 32'(bus0.Ready), 32'd1);
      pushExpected(0, b2b[i].tag, b2b[i].dout, b2b[i].err);
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 9'h000, 32'h0);

    repeat (6) @(negedge clk);
    checkOutput("sb1_drained", 32'(sb1.size()), 32'd0);
    checkOutput("sb0_drained", 32'(sb0.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
